// File: rtl/spi_mem_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// spi_mem_ctrl_if : request/response bundle between control unit and SPI master
// Revision: 1.0
// ----------------------------------------------------------------------------
interface spi_mem_ctrl_if;
  logic        req;
  logic        we;
  logic        sel;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        done;
  logic        busy;

  modport master (output req, we, sel, addr, wdata, input  rdata, done, busy);
  modport slave  (input  req, we, sel, addr, wdata, output rdata, done, busy);
endinterface
`default_nettype wire

// File: rtl/spi_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// spi_mem_ctrl : single-byte SPI mode-0 read/write master for program ROM / data RAM
// Revision: 1.0
// ----------------------------------------------------------------------------
module spi_mem_ctrl #(
  parameter int unsigned CLK_DIV   = 1,
  parameter logic [7:0]  CMD_READ  = 8'h03,
  parameter logic [7:0]  CMD_WRITE = 8'h02
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  spi_mem_ctrl_if.slave bus,
  output logic          sck_o,
  output logic          mosi_o,
  input  wire logic     miso_i,
  output logic          cs_rom_n_o,
  output logic          cs_ram_n_o
);

  localparam int unsigned       CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT    = 3'd2,
    HOLD     = 3'd3,
    DONE     = 3'd4,
    WAIT_REL = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             armed_q, armed_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             cs_rom_n_q, cs_rom_n_d;
  logic             cs_ram_n_q, cs_ram_n_d;
  logic             we_q, we_d;
  logic [31:0]      sreg_q, sreg_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [4:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      armed_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cs_rom_n_q <= 1'b1;
      cs_ram_n_q <= 1'b1;
      we_q       <= 1'b0;
      sreg_q     <= 32'h0;
      rx_q       <= 8'h00;
      rdata_q    <= 8'h00;
      bit_q      <= 5'd0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      cs_rom_n_q <= cs_rom_n_d;
      cs_ram_n_q <= cs_ram_n_d;
      we_q       <= we_d;
      sreg_q     <= sreg_d;
      rx_q       <= rx_d;
      rdata_q    <= rdata_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    cs_rom_n_d = cs_rom_n_q;
    cs_ram_n_d = cs_ram_n_q;
    we_d       = we_q;
    sreg_d     = sreg_q;
    rx_d       = rx_q;
    rdata_d    = rdata_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req && armed_q) begin
          armed_d = 1'b0;
          busy_d  = 1'b1;
          we_d    = bus.we;
          cnt_d   = '0;
          bit_d   = 5'd0;
          sreg_d  = {bus.we ? CMD_WRITE : CMD_READ, bus.addr, bus.we ? bus.wdata : 8'h00};
          // Program ROM is read-only: a write completes without touching the bus.
          if (bus.we && !bus.sel) begin
            state_d = DONE;
          end else begin
            state_d    = SETUP;
            cs_rom_n_d = bus.sel;
            cs_ram_n_d = !bus.sel;
            mosi_d     = sreg_d[31];
          end
        end
      end

      SETUP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SHIFT: begin
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
            // Only the final byte of the frame carries read data.
            if (bit_q[4:3] == 2'b11) begin
              rx_d = {rx_q[6:0], miso_i};
            end
          end else begin
            sck_d  = 1'b0;
            sreg_d = {sreg_q[30:0], 1'b0};
            mosi_d = sreg_q[30];
            if (bit_q == 5'd31) begin
              state_d = HOLD;
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end
      end

      HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d      = '0;
          state_d    = DONE;
          cs_rom_n_d = 1'b1;
          cs_ram_n_d = 1'b1;
          mosi_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        rdata_d = we_q ? rdata_q : rx_q;
        state_d = WAIT_REL;
      end

      WAIT_REL: begin
        if (!bus.req) begin
          armed_d = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.rdata  = rdata_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign sck_o      = sck_q;
  assign mosi_o     = mosi_q;
  assign cs_rom_n_o = cs_rom_n_q;
  assign cs_ram_n_o = cs_ram_n_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// tb_spi_mem_ctrl : scoreboard bench for spi_mem_ctrl, one CLK_DIV=1 and one CLK_DIV=3 instance
// sharing a behavioural SPI memory model inside the monitor process.
module tb_spi_mem_ctrl;

  typedef struct {
    int          inst;
    logic [31:0] frame;
    logic [7:0]  rdata;
    int          lat;
    int          ram_cyc;
    int          rom_cyc;
    int          rises;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_mem_ctrl_if bus1 ();
  spi_mem_ctrl_if bus3 ();

  wire  [1:0] sck_w, mosi_w, csr_w, csm_w;
  logic [1:0] miso_r = 2'b00;
  logic [7:0] resp [2];
  wire  [1:0] done_w = {bus3.done, bus1.done};
  wire  [1:0] busy_w = {bus3.busy, bus1.busy};
  wire  [7:0] rdata_w [2];
  assign rdata_w[0] = bus1.rdata;
  assign rdata_w[1] = bus3.rdata;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   viol   = 0;

  spi_mem_ctrl #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
    .sck_o(sck_w[0]), .mosi_o(mosi_w[0]), .miso_i(miso_r[0]),
    .cs_rom_n_o(csr_w[0]), .cs_ram_n_o(csm_w[0])
  );

  spi_mem_ctrl #(.CLK_DIV(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave),
    .sck_o(sck_w[1]), .mosi_o(mosi_w[1]), .miso_i(miso_r[1]),
    .cs_rom_n_o(csr_w[1]), .cs_ram_n_o(csm_w[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int inst, input logic req, input logic we, input logic sel,
                       input logic [15:0] a, input logic [7:0] wd);
    if (inst == 0) begin
      bus1.req = req; bus1.we = we; bus1.sel = sel; bus1.addr = a; bus1.wdata = wd;
    end else begin
      bus3.req = req; bus3.we = we; bus3.sel = sel; bus3.addr = a; bus3.wdata = wd;
    end
  endtask

  // Pushes the expected response, raises req, waits for done, then holds req for 'hold' cycles.
  task automatic issue(input int inst, input logic we, input logic sel, input logic [15:0] a,
                       input logic [7:0] wd, input logic [7:0] rsp, input logic [31:0] frame,
                       input logic [7:0] exp_rd, input int hold, input bit drop_early);
    exp_t e;
    int   d;
    bit   romw;
    bit   got;
    d         = (inst == 0) ? 1 : 3;
    romw      = we && !sel;
    e.inst    = inst;
    e.frame   = frame;
    e.rdata   = exp_rd;
    e.lat     = romw ? 1 : 66 * d + 1;
    e.ram_cyc = (!romw && sel)  ? 66 * d : 0;
    e.rom_cyc = (!romw && !sel) ? 66 * d : 0;
    e.rises   = romw ? 0 : 32;
    resp[inst] = rsp;
    exp_q.push_back(e);
    @(negedge clk);
    drive(inst, 1'b1, we, sel, a, wd);
    got = 1'b0;
    for (int n = 0; n < 1000 && !got; n++) begin
      @(negedge clk);
      if (drop_early && n == 10) drive(inst, 1'b0, ~we, ~sel, 16'h1111, 8'hEE);
      if (done_w[inst]) got = 1'b1;
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    repeat (hold) @(negedge clk);
    drive(inst, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  // SPI memory model plus per-transaction observer; pops the scoreboard on every done pulse.
  task automatic monitor();
    logic [1:0]  sck_p, cs_p, busy_p;
    int          lat [2];
    int          ramc [2];
    int          romc [2];
    int          rises [2];
    int          fcnt [2];
    logic [31:0] cap [2];
    logic        csn;
    exp_t        e;
    sck_p = 2'b00; cs_p = 2'b11; busy_p = 2'b00;
    for (int i = 0; i < 2; i++) begin
      lat[i] = 0; ramc[i] = 0; romc[i] = 0; rises[i] = 0; fcnt[i] = 0; cap[i] = 32'h0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        csn = csm_w[i] & csr_w[i];
        if (!rst_n) begin
          sck_p[i] = 1'b0; cs_p[i] = 1'b1; busy_p[i] = 1'b0; miso_r[i] = 1'b0;
        end else begin
          if (busy_w[i] && !busy_p[i]) begin
            lat[i] = 0; ramc[i] = 0; romc[i] = 0; rises[i] = 0; cap[i] = 32'h0;
          end else begin
            lat[i]++;
          end
          if (!csm_w[i]) ramc[i]++;
          if (!csr_w[i]) romc[i]++;
          if (!csm_w[i] && !csr_w[i]) viol++;
          if (csn && mosi_w[i]) viol++;
          if (!csn && cs_p[i]) begin
            fcnt[i] = 0; miso_r[i] = 1'b0;
          end
          if (sck_w[i] && !sck_p[i]) begin
            rises[i]++;
            cap[i] = {cap[i][30:0], mosi_w[i]};
          end
          if (!sck_w[i] && sck_p[i]) begin
            fcnt[i]++;
            miso_r[i] = (fcnt[i] >= 24 && fcnt[i] < 32) ? resp[i][3'(31 - fcnt[i])] : 1'b0;
          end
          if (done_w[i]) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done: done pulse on instance %0d, expected none", i);
            end else begin
              e = exp_q.pop_front();
              check("done_instance", 32'(i), 32'(e.inst));
              check("rdata", 32'(rdata_w[i]), 32'(e.rdata));
              check("latency", 32'(lat[i]), 32'(e.lat));
              check("cs_ram_low_cycles", 32'(ramc[i]), 32'(e.ram_cyc));
              check("cs_rom_low_cycles", 32'(romc[i]), 32'(e.rom_cyc));
              check("sck_rises", 32'(rises[i]), 32'(e.rises));
              if (e.rises != 0) check("mosi_frame", cap[i], e.frame);
            end
          end
          sck_p[i]  = sck_w[i];
          cs_p[i]   = csn;
          busy_p[i] = busy_w[i];
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    resp[0] = 8'h00;
    resp[1] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_sck",      32'(sck_w[0]),   32'd0);
    check("reset_mosi",     32'(mosi_w[0]),  32'd0);
    check("reset_cs_rom_n", 32'(csr_w[0]),   32'd1);
    check("reset_cs_ram_n", 32'(csm_w[0]),   32'd1);
    check("reset_done",     32'(done_w[0]),  32'd0);
    check("reset_busy",     32'(busy_w[0]),  32'd0);
    check("reset_rdata",    32'(rdata_w[0]), 32'd0);
    rst_n = 1'b1;

    issue(0, 1'b0, 1'b1, 16'h1234, 8'h00, 8'hA5, 32'h0312_3400, 8'hA5, 0, 1'b0);
    issue(0, 1'b1, 1'b1, 16'hBEEF, 8'h5A, 8'h77, 32'h02BE_EF5A, 8'hA5, 0, 1'b0);
    issue(0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h3C, 32'h0300_0000, 8'h3C, 0, 1'b0);
    issue(0, 1'b0, 1'b0, 16'hFFFF, 8'h00, 8'hC3, 32'h03FF_FF00, 8'hC3, 0, 1'b1);
    issue(0, 1'b1, 1'b0, 16'h0040, 8'hFF, 8'h00, 32'h0000_0000, 8'hC3, 0, 1'b0);

    issue(0, 1'b0, 1'b1, 16'h0102, 8'h00, 8'h11, 32'h0301_0200, 8'h11, 200, 1'b0);
    check("held_req_idle_busy", 32'(busy_w[0]), 32'd0);
    issue(0, 1'b0, 1'b1, 16'h0102, 8'h00, 8'h22, 32'h0301_0200, 8'h22, 0, 1'b0);

    resp[0] = 8'hF0;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b1, 16'h5555, 8'h00);
    repeat (22) @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    check("abort_sck",      32'(sck_w[0]),   32'd0);
    check("abort_cs_rom_n", 32'(csr_w[0]),   32'd1);
    check("abort_cs_ram_n", 32'(csm_w[0]),   32'd1);
    check("abort_done",     32'(done_w[0]),  32'd0);
    check("abort_busy",     32'(busy_w[0]),  32'd0);
    check("abort_rdata",    32'(rdata_w[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(0, 1'b0, 1'b1, 16'h4321, 8'h00, 8'h96, 32'h0343_2100, 8'h96, 0, 1'b0);

    issue(1, 1'b0, 1'b1, 16'h00FF, 8'h00, 8'h81, 32'h0300_FF00, 8'h81, 0, 1'b0);

    repeat (5) @(negedge clk);
    check("cs_mosi_violations", 32'(viol), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
